reboot_scheduler: RTL and testbench



---
 rtl/reboot_scheduler.sv | 169 ++++++++++++++++
 tb/tb_reboot_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reboot_scheduler.sv
// Warm-reboot arbiter: qualifies a held request from A or B, waits for the
// datapath to go quiet, then fires a one-cycle reboot pulse with a flash
// address for the ICAP multiboot sequencer, and locks until reset.
//
// Ports:
//   clock, reset   - system clock, asynchronous active-low reset
//   req_a, slot_a  - requester A (higher priority) and its target slot
//   req_b, slot_b  - requester B and its target slot
//   quiesce        - high when no SDRAM/SD write is in flight
//   busy           - high in every state except IDLE
//   grant          - one-hot owner (bit0 = A, bit1 = B), 0 in IDLE
//   reboot         - one-cycle pulse to the ICAP sequencer
//   addr           - bitstream address, valid from WAIT_Q onward
//   forced         - sticky, set when firing was caused by the timeout
module reboot_scheduler #(
  parameter logic [15:0] HOLD    = 16'd50000,
  parameter logic [7:0]  SETTLE  = 8'd8,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF,
  parameter logic [23:0] BASE    = 24'h000000,
  parameter logic [23:0] STRIDE  = 24'h0B0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_a,
  input  logic [1:0]  slot_a,
  input  logic        req_b,
  input  logic [1:0]  slot_b,
  input  logic        quiesce,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        reboot,
  output logic [23:0] addr,
  output logic        forced
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_Q,
    S_SETTLE,
    S_FIRE,
    S_LOCK
  } state_t;

  state_t      state;
  logic [15:0] hold_cnt;
  logic [7:0]  settle_cnt;
  logic [23:0] tmo_cnt;
  logic [1:0]  slot_q;
  logic        owner_b;

  logic        owner_req;
  logic [1:0]  owner_slot;
  logic [23:0] slot_addr;
  logic        tmo_hit;

  // Request and slot of whichever requester currently owns the arbiter.
  assign owner_req  = owner_b ? req_b  : req_a;
  assign owner_slot = owner_b ? slot_b : slot_a;

  // Flash address wraps modulo 2^24 by truncation to the 24-bit result.
  assign slot_addr  = BASE + STRIDE * {22'd0, slot_q};

  // The timeout counter is shared by WAIT_Q and SETTLE and is not cleared
  // when bouncing between them, so the bound covers the whole wait phase.
  assign tmo_hit    = (tmo_cnt == TIMEOUT - 24'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      slot_q     <= '0;
      owner_b    <= 1'b0;
      busy       <= 1'b0;
      grant      <= 2'b00;
      reboot     <= 1'b0;
      addr       <= BASE;
      forced     <= 1'b0;
    end else begin
      reboot <= 1'b0;
      case (state)
        S_IDLE: begin
          hold_cnt <= '0;
          if (req_a) begin
            owner_b <= 1'b0;
            slot_q  <= slot_a;
            grant   <= 2'b01;
            busy    <= 1'b1;
            state   <= S_ARM;
          end else if (req_b) begin
            owner_b <= 1'b1;
            slot_q  <= slot_b;
            grant   <= 2'b10;
            busy    <= 1'b1;
            state   <= S_ARM;
          end
        end

        S_ARM: begin
          if (!owner_req) begin
            hold_cnt <= '0;
            grant    <= 2'b00;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (owner_slot != slot_q) begin
            // A changed target restarts qualification from scratch.
            slot_q   <= owner_slot;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD) begin
            addr    <= slot_addr;
            tmo_cnt <= '0;
            state   <= S_WAIT_Q;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end

        S_WAIT_Q: begin
          if (tmo_hit) begin
            forced <= 1'b1;
            reboot <= 1'b1;
            state  <= S_FIRE;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
            if (quiesce) begin
              settle_cnt <= '0;
              state      <= S_SETTLE;
            end
          end
        end

        S_SETTLE: begin
          // Timeout wins over both a quiesce drop and settle completion.
          if (tmo_hit) begin
            forced <= 1'b1;
            reboot <= 1'b1;
            state  <= S_FIRE;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
            if (!quiesce) begin
              state <= S_WAIT_Q;
            end else if (settle_cnt == SETTLE - 8'd1) begin
              reboot <= 1'b1;
              state  <= S_FIRE;
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
        end

        S_FIRE: begin
          state <= S_LOCK;
        end

        S_LOCK: begin
          // Terminal until reset: the FPGA is reconfiguring.
          state <= S_LOCK;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reboot_scheduler.sv
// Testbench for reboot_scheduler: directed scenarios plus randomized
// episodes checked against a behavioural reference model.
module tb_reboot_scheduler;

  localparam int HOLD    = 4;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 20;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_WAIT = 2;
  localparam int P_FIRE = 3;
  localparam int P_LOCK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0;
  logic [1:0]  slot_a = 2'd0;
  logic        req_b = 1'b0;
  logic [1:0]  slot_b = 2'd0;
  logic        quiesce = 1'b0;

  logic        busy0, reboot0, forced0, busy1, reboot1, forced1;
  logic [1:0]  grant0, grant1;
  logic [23:0] addr0, addr1;

  int checks = 0;
  int failures = 0;

  // Reference model state: phase, owner (0 none, 1 A, 2 B), run lengths.
  int          m_phase, m_owner, m_run, m_age, m_qrun;
  logic [1:0]  m_slot;
  logic        m_forced;
  logic [23:0] m_addr0, m_addr1;

  always #5 clk = ~clk;

  reboot_scheduler #(
    .HOLD(16'd4), .SETTLE(8'd2), .TIMEOUT(24'd20),
    .BASE(24'h000000), .STRIDE(24'h0B0000)
  ) dut (
    .clock(clk), .reset(rst_n),
    .req_a(req_a), .slot_a(slot_a), .req_b(req_b), .slot_b(slot_b),
    .quiesce(quiesce),
    .busy(busy0), .grant(grant0), .reboot(reboot0), .addr(addr0), .forced(forced0)
  );

  reboot_scheduler #(
    .HOLD(16'd4), .SETTLE(8'd2), .TIMEOUT(24'd20),
    .BASE(24'hF00000), .STRIDE(24'h0B0000)
  ) dut_w (
    .clock(clk), .reset(rst_n),
    .req_a(req_a), .slot_a(slot_a), .req_b(req_b), .slot_b(slot_b),
    .quiesce(quiesce),
    .busy(busy1), .grant(grant1), .reboot(reboot1), .addr(addr1), .forced(forced1)
  );

  function automatic logic [23:0] slot_to_addr(input logic [23:0] base, input logic [1:0] s);
    logic [31:0] full;
    full = {8'd0, base} + {30'd0, s} * 32'h000B_0000;
    return full[23:0];
  endfunction

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_owner  = 0;
    m_run    = 0;
    m_age    = 0;
    m_qrun   = 0;
    m_slot   = 2'd0;
    m_forced = 1'b0;
    m_addr0  = 24'h000000;
    m_addr1  = 24'hF00000;
  endtask

  // Acceptance after HOLD+1 consecutive stable ARM edges; firing when the
  // wait phase sees SETTLE+1 consecutive quiesce-high edges, or at its
  // TIMEOUT-th edge (timeout takes precedence).
  task automatic model_step();
    logic       oreq;
    logic [1:0] oslot;
    case (m_phase)
      P_IDLE: begin
        if (req_a) begin
          m_owner = 1; m_slot = slot_a; m_run = 0; m_phase = P_ARM;
        end else if (req_b) begin
          m_owner = 2; m_slot = slot_b; m_run = 0; m_phase = P_ARM;
        end
      end
      P_ARM: begin
        oreq  = (m_owner == 1) ? req_a  : req_b;
        oslot = (m_owner == 1) ? slot_a : slot_b;
        if (!oreq) begin
          m_phase = P_IDLE; m_owner = 0;
        end else if (oslot != m_slot) begin
          m_slot = oslot; m_run = 0;
        end else begin
          m_run++;
          if (m_run == HOLD + 1) begin
            m_phase = P_WAIT; m_age = 0; m_qrun = 0;
            m_addr0 = slot_to_addr(24'h000000, m_slot);
            m_addr1 = slot_to_addr(24'hF00000, m_slot);
          end
        end
      end
      P_WAIT: begin
        m_age++;
        m_qrun = quiesce ? m_qrun + 1 : 0;
        if (m_age == TIMEOUT) begin
          m_phase = P_FIRE; m_forced = 1'b1;
        end else if (m_qrun == SETTLE + 1) begin
          m_phase = P_FIRE;
        end
      end
      P_FIRE: m_phase = P_LOCK;
      default: ;
    endcase
  endtask

  // One clock: model advances on the edge, outputs are observed on the
  // following falling edge where inputs may then be changed.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; slot_a = 2'd0; slot_b = 2'd0; quiesce = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy0 !== 1'b0 || grant0 !== 2'b00 || reboot0 !== 1'b0 || forced0 !== 1'b0 || addr0 !== 24'h000000) begin
      failures++;
      $display("FAIL reset_state busy=%b grant=%b reboot=%b forced=%b addr=%h expected 0/00/0/0/000000",
               busy0, grant0, reboot0, forced0, addr0);
    end
    checks++;
    if (addr1 !== 24'hF00000 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_base addr=%h busy=%b expected f00000/0", addr1, busy1);
    end
  endtask

  task automatic test_basic();
    int pulses, edge_at;
    do_reset();
    quiesce = 1'b1; req_b = 1'b1; slot_b = 2'd1;
    pulses = 0; edge_at = -1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (reboot0) begin pulses++; edge_at = k; end
      if (k == 0) begin
        checks++;
        if (grant0 !== 2'b10) begin
          failures++;
          $display("FAIL basic_grant got=%b expected 10", grant0);
        end
      end
    end
    checks++;
    if (pulses != 1 || edge_at != 8) begin
      failures++;
      $display("FAIL basic_pulse count=%0d edge=%0d expected 1 at edge 8", pulses, edge_at);
    end
    checks++;
    if (addr0 !== 24'h0B0000 || busy0 !== 1'b1 || forced0 !== 1'b0) begin
      failures++;
      $display("FAIL basic_outputs addr=%h busy=%b forced=%b expected 0b0000/1/0", addr0, busy0, forced0);
    end
    req_b = 1'b0; req_a = 1'b1; slot_a = 2'd2;
    pulses = 0;
    repeat (10) begin
      tick();
      if (reboot0) pulses++;
    end
    checks++;
    if (pulses != 0 || grant0 !== 2'b10 || addr0 !== 24'h0B0000 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL basic_lock pulses=%0d grant=%b addr=%h busy=%b expected 0/10/0b0000/1",
               pulses, grant0, addr0, busy0);
    end
  endtask

  task automatic test_priority();
    int edge_at;
    do_reset();
    quiesce = 1'b1; req_a = 1'b1; req_b = 1'b1; slot_a = 2'd2; slot_b = 2'd3;
    edge_at = -1;
    for (int k = 0; k <= 12; k++) begin
      tick();
      if (reboot0) edge_at = k;
    end
    checks++;
    if (grant0 !== 2'b01 || addr0 !== 24'h160000 || edge_at != 8) begin
      failures++;
      $display("FAIL priority grant=%b addr=%h edge=%0d expected 01/160000/8", grant0, addr0, edge_at);
    end
  endtask

  task automatic test_withdraw();
    int edge_at;
    do_reset();
    quiesce = 1'b1; req_a = 1'b1; slot_a = 2'd1; req_b = 1'b1; slot_b = 2'd0;
    tick(); tick(); tick();
    req_a = 1'b0;
    tick();
    checks++;
    if (grant0 !== 2'b00 || busy0 !== 1'b0 || reboot0 !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_idle grant=%b busy=%b reboot=%b expected 00/0/0", grant0, busy0, reboot0);
    end
    tick();
    checks++;
    if (grant0 !== 2'b10 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL withdraw_regrant grant=%b busy=%b expected 10/1", grant0, busy0);
    end
    edge_at = -1;
    for (int k = 5; k <= 20; k++) begin
      tick();
      if (reboot0) edge_at = k;
    end
    checks++;
    if (edge_at != 12 || addr0 !== 24'h000000) begin
      failures++;
      $display("FAIL withdraw_fire edge=%0d addr=%h expected 12/000000", edge_at, addr0);
    end
  endtask

  task automatic test_slot_change();
    int edge_at;
    do_reset();
    quiesce = 1'b1; req_a = 1'b1; slot_a = 2'd0;
    edge_at = -1;
    for (int k = 0; k <= 20; k++) begin
      if (k == 3) slot_a = 2'd1;
      tick();
      if (reboot0) edge_at = k;
    end
    checks++;
    if (edge_at != 11 || addr0 !== 24'h0B0000) begin
      failures++;
      $display("FAIL slot_change edge=%0d addr=%h expected 11/0b0000", edge_at, addr0);
    end
  endtask

  task automatic test_timeout();
    int edge_at;
    do_reset();
    quiesce = 1'b0; req_a = 1'b1; slot_a = 2'd2;
    edge_at = -1;
    for (int k = 0; k <= 40; k++) begin
      tick();
      if (reboot0) edge_at = k;
      if (k == 24) begin
        checks++;
        if (forced0 !== 1'b0) begin
          failures++;
          $display("FAIL timeout_early forced=%b expected 0", forced0);
        end
      end
    end
    checks++;
    if (edge_at != 25 || forced0 !== 1'b1 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL timeout_fire edge=%0d forced=%b busy=%b expected 25/1/1", edge_at, forced0, busy0);
    end
  endtask

  task automatic test_glitch();
    int edge_at;
    do_reset();
    req_a = 1'b1; slot_a = 2'd0;
    edge_at = -1;
    for (int k = 0; k <= 20; k++) begin
      quiesce = (k != 7);
      tick();
      if (reboot0) edge_at = k;
    end
    checks++;
    if (edge_at != 10 || forced0 !== 1'b0) begin
      failures++;
      $display("FAIL glitch edge=%0d forced=%b expected 10/0", edge_at, forced0);
    end
  endtask

  task automatic test_wrap_reset();
    int pulses;
    do_reset();
    quiesce = 1'b1; req_a = 1'b1; slot_a = 2'd3;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        checks++;
        if (addr1 !== 24'h110000 || addr0 !== 24'h210000) begin
          failures++;
          $display("FAIL wrap_addr wrap=%h plain=%h expected 110000/210000", addr1, addr0);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b0 || grant0 !== 2'b00 || reboot0 !== 1'b0 || forced0 !== 1'b0 || addr0 !== 24'h000000 ||
        busy1 !== 1'b0 || grant1 !== 2'b00 || reboot1 !== 1'b0 || addr1 !== 24'hF00000) begin
      failures++;
      $display("FAIL async_reset busy=%b/%b grant=%b/%b reboot=%b/%b addr=%h/%h expected idle values",
               busy0, busy1, grant0, grant1, reboot0, reboot1, addr0, addr1);
    end
    pulses = 0;
    repeat (3) begin
      tick();
      if (reboot0 || reboot1) pulses++;
    end
    rst_n = 1'b1; req_a = 1'b0;
    repeat (10) begin
      tick();
      if (reboot0 || reboot1) pulses++;
    end
    checks++;
    if (pulses != 0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_pulse pulses=%0d busy=%b expected 0/0", pulses, busy0);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_grant;
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      slot_a = 2'($urandom_range(0, 3));
      slot_b = 2'($urandom_range(0, 3));
      for (int cyc = 0; cyc < 150; cyc++) begin
        req_a   = ($urandom_range(0, 99) < ((ep % 2) != 0 ? 90 : 30));
        req_b   = ($urandom_range(0, 99) < 90);
        if ($urandom_range(0, 9) == 0) slot_a = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) slot_b = 2'($urandom_range(0, 3));
        quiesce = ($urandom_range(0, 99) < (ep < 3 ? 80 : 15));
        tick();
        exp_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        checks++;
        if (busy0 !== (m_phase != P_IDLE) || grant0 !== exp_grant) begin
          failures++;
          if (failures < 20)
            $display("FAIL rand_ctrl ep=%0d cyc=%0d busy=%b grant=%b expected %b/%b",
                     ep, cyc, busy0, grant0, (m_phase != P_IDLE), exp_grant);
        end
        checks++;
        if (reboot0 !== (m_phase == P_FIRE) || forced0 !== m_forced) begin
          failures++;
          if (failures < 20)
            $display("FAIL rand_fire ep=%0d cyc=%0d reboot=%b forced=%b expected %b/%b",
                     ep, cyc, reboot0, forced0, (m_phase == P_FIRE), m_forced);
        end
        checks++;
        if (addr0 !== m_addr0 || addr1 !== m_addr1) begin
          failures++;
          if (failures < 20)
            $display("FAIL rand_addr ep=%0d cyc=%0d addr=%h/%h expected %h/%h",
                     ep, cyc, addr0, addr1, m_addr0, m_addr1);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_priority();
    test_withdraw();
    test_slot_change();
    test_timeout();
    test_glitch();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
